// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, ALU controls, FSM states.
package mdu_pkg;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam int ITER_COUNT = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_NEG_A  = 3'd1,
      ST_NEG_B  = 3'd2,
      ST_ITER   = 3'd3,
      ST_NEG_LO = 3'd4,
      ST_NEG_HI = 3'd5,
      ST_DONE   = 3'd6
   } state_e;

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return (op == OP_DIVU) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Pipeline-side handshake and result bus of the multiply/divide sequencer.
interface mdu_seq_if #(parameter int WIDTH = 32);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             abort;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, abort, input busy, done, hi, lo);
   modport slave  (input start, op, a, b, abort, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_seq_alu.sv
// Shared 32-bit ALU; the sequencer only ever drives ADD and SUB into it.
module mdu_seq_alu
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_control,
   output logic [WIDTH-1:0] y,
   output logic             zero
);

   logic [WIDTH-1:0] diff;

   assign diff = a - b;

   always_comb begin
      y = '0;
      case (alu_control)
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_ADD: y = a + b;
         ALU_SUB: y = diff;
         ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_NOR: y = ~(a | b);
         default: y = '0;
      endcase
   end

   assign zero = (y == '0);

endmodule

// File: rtl/mdu_seq.sv
// Iterative MULTU/MULT/DIVU/DIV sequencer; every add/sub/negate goes through one shared ALU.
//
//   state   | meaning
//   IDLE    | waiting for start; accept latches a, b, op
//   NEG_A   | signed: a <= |a|, record sign_a
//   NEG_B   | signed: b <= |b|, record sign_b, seed {acc, mq}
//   ITER    | 32 shift-add / restoring-divide steps
//   NEG_LO  | signed: conditional negate of lo
//   NEG_HI  | signed: conditional negate of hi, HI/LO written
//   DONE    | done pulse, back to IDLE
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   mdu_seq_if.slave   bus
);

   state_e           state;
   state_e           state_nxt;

   logic [1:0]       op_q;
   logic [WIDTH-1:0] opa, opa_nxt;
   logic [WIDTH-1:0] opb, opb_nxt;
   logic [WIDTH-1:0] acc, acc_nxt;
   logic [WIDTH-1:0] mq, mq_nxt;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic [4:0]       cnt;
   logic             sign_a, sign_b;

   logic             accept;
   logic             last_iter;
   logic             is_div, is_signed;
   logic             hl_we;

   logic [WIDTH-1:0] alu_a, alu_b, alu_y;
   logic [3:0]       alu_ctl;
   logic             alu_zero_unused;

   logic [WIDTH-1:0] sum;
   logic             carry;
   logic [WIDTH-1:0] rem_s;
   logic [WIDTH-1:0] q_s;
   logic [WIDTH-1:0] b_abs;

   mdu_seq_alu #(.WIDTH(WIDTH)) u_alu (
      .a           (alu_a),
      .b           (alu_b),
      .alu_control (alu_ctl),
      .y           (alu_y),
      .zero        (alu_zero_unused)
   );

   assign is_div    = op_is_div(op_q);
   assign is_signed = op_is_signed(op_q);
   assign last_iter = (cnt == 5'(ITER_COUNT - 1));
   assign accept    = (state == ST_IDLE) && bus.start && !bus.abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // abort outranks every transition; reset is handled by the register itself
   always_comb begin
      state_nxt = state;
      if (bus.abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   if (bus.start) state_nxt = op_is_signed(bus.op) ? ST_NEG_A : ST_ITER;
            ST_NEG_A:  state_nxt = ST_NEG_B;
            ST_NEG_B:  state_nxt = ST_ITER;
            ST_ITER:   if (last_iter) state_nxt = is_signed ? ST_NEG_LO : ST_DONE;
            ST_NEG_LO: state_nxt = ST_NEG_HI;
            ST_NEG_HI: state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.busy = (state != ST_IDLE);
      bus.done = (state == ST_DONE);
      hl_we    = !bus.abort &&
                 (((state == ST_ITER) && last_iter && !is_signed) || (state == ST_NEG_HI));
   end

   always_comb begin
      opa_nxt = opa;
      opb_nxt = opb;
      acc_nxt = acc;
      mq_nxt  = mq;
      alu_a   = '0;
      alu_b   = '0;
      alu_ctl = ALU_ADD;
      sum     = acc;
      carry   = 1'b0;
      rem_s   = '0;
      q_s     = '0;
      b_abs   = opb;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               opa_nxt = bus.a;
               opb_nxt = bus.b;
               acc_nxt = '0;
               mq_nxt  = op_is_div(bus.op) ? bus.a : bus.b;
            end
         end
         ST_NEG_A: begin
            alu_b   = opa;
            alu_ctl = ALU_SUB;
            if (opa[WIDTH-1]) opa_nxt = alu_y;
         end
         ST_NEG_B: begin
            alu_b   = opb;
            alu_ctl = ALU_SUB;
            b_abs   = opb[WIDTH-1] ? alu_y : opb;
            opb_nxt = b_abs;
            acc_nxt = '0;
            mq_nxt  = is_div ? opa : b_abs;
         end
         ST_ITER: begin
            if (!is_div) begin
               alu_a   = acc;
               alu_b   = opa;
               alu_ctl = ALU_ADD;
               if (mq[0]) begin
                  sum   = alu_y;
                  carry = (alu_y < acc);
               end
               acc_nxt = {carry, sum[WIDTH-1:1]};
               mq_nxt  = {sum[0], mq[WIDTH-1:1]};
            end else begin
               rem_s   = {acc[WIDTH-2:0], mq[WIDTH-1]};
               q_s     = {mq[WIDTH-2:0], 1'b0};
               alu_a   = rem_s;
               alu_b   = opb;
               alu_ctl = ALU_SUB;
               // acc[MSB] is the 33rd remainder bit shifted out; when set rem > d always
               if (acc[WIDTH-1] || (rem_s >= opb)) begin
                  acc_nxt = alu_y;
                  mq_nxt  = {q_s[WIDTH-1:1], 1'b1};
               end else begin
                  acc_nxt = rem_s;
                  mq_nxt  = q_s;
               end
            end
         end
         ST_NEG_LO: begin
            alu_b   = mq;
            alu_ctl = ALU_SUB;
            if (sign_a ^ sign_b) mq_nxt = alu_y;
         end
         ST_NEG_HI: begin
            if (!is_div) begin
               alu_a   = ~acc;
               alu_b   = {{(WIDTH-1){1'b0}}, (mq == '0)};
               alu_ctl = ALU_ADD;
               if (sign_a ^ sign_b) acc_nxt = alu_y;
            end else begin
               alu_b   = acc;
               alu_ctl = ALU_SUB;
               if (sign_a) acc_nxt = alu_y;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= OP_MULTU;
         opa    <= '0;
         opb    <= '0;
         acc    <= '0;
         mq     <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         cnt    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else if (!bus.abort) begin
         opa <= opa_nxt;
         opb <= opb_nxt;
         acc <= acc_nxt;
         mq  <= mq_nxt;
         if (accept) op_q <= bus.op;
         if (state == ST_NEG_A) sign_a <= opa[WIDTH-1];
         if (state == ST_NEG_B) sign_b <= opb[WIDTH-1];
         cnt <= (state == ST_ITER) ? cnt + 5'd1 : 5'd0;
         if (hl_we) begin
            hi_q <= acc_nxt;
            lo_q <= mq_nxt;
         end
      end else begin
         cnt <= '0;
      end
   end

   assign bus.hi = hi_q;
   assign bus.lo = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: arithmetic vectors, latency, ignored start, abort and async reset.
module tb_mdu_seq;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   mdu_seq_if #(.WIDTH(32)) bus();

   mdu_seq #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      bit got;
      bit busy_ok;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk({tag, "_busy_rise"}, bus.busy, 1);
      n = 0; got = 0; busy_ok = 1;
      while (!got && n < 60) begin
         @(posedge clk); #1;
         n++;
         if (!bus.busy) busy_ok = 0;
         if (bus.done) got = 1;
      end
      chk({tag, "_latency"}, n, lat);
      chk({tag, "_busy_held"}, busy_ok, 1);
      chk({tag, "_hi"}, bus.hi, exp_hi);
      chk({tag, "_lo"}, bus.lo, exp_lo);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, bus.done, 0);
      chk({tag, "_busy_fall"}, bus.busy, 0);
   endtask

   initial begin
      int  n;
      bit  got;
      bit  seen_done;

      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.op    = 2'b00;
      bus.a     = '0;
      bus.b     = '0;
      #12;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_hi", bus.hi, 0);
      chk("rst_lo", bus.lo, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'hFFFFFFFE, 32'h00000001);
      run_op("mult_neg3x5", 2'b01, 32'hFFFFFFFD, 32'h00000005, 36, 32'hFFFFFFFF, 32'hFFFFFFF1);
      run_op("div_neg7d2", 2'b11, 32'hFFFFFFF9, 32'h00000002, 36, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("divu_7d0", 2'b10, 32'h00000007, 32'h00000000, 32, 32'h00000007, 32'hFFFFFFFF);
      run_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 36, 32'h00000000, 32'h80000000);
      run_op("multu_shift", 2'b00, 32'h12345678, 32'h00000100, 32, 32'h00000012, 32'h34567800);

      // second start during iteration 5 must not restart or change the result
      bus.op = 2'b00; bus.a = 32'h00001000; bus.b = 32'h00000003; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      bus.op = 2'b10; bus.a = 32'h1; bus.b = 32'h1; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 6; got = 0;
      while (!got && n < 60) begin
         @(posedge clk); #1;
         n++;
         if (bus.done) got = 1;
      end
      chk("ign_start_latency", n, 32);
      chk("ign_start_hi", bus.hi, 32'h00000000);
      chk("ign_start_lo", bus.lo, 32'h00003000);
      @(posedge clk); #1;
      chk("ign_start_idle", bus.busy, 0);

      // abort at iteration 10
      bus.op = 2'b10; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_hi", bus.hi, 32'h00000000);
      chk("abort_lo", bus.lo, 32'h00003000);
      seen_done = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) seen_done = 1;
      end
      chk("abort_no_done", seen_done, 0);
      chk("abort_hi_hold", bus.hi, 32'h00000000);
      chk("abort_lo_hold", bus.lo, 32'h00003000);

      // abort together with start in IDLE: nothing accepted
      bus.op = 2'b00; bus.a = 32'd5; bus.b = 32'd5; bus.start = 1'b1; bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.abort = 1'b0;
      chk("abort_start_busy", bus.busy, 0);
      @(posedge clk); #1;
      chk("abort_start_busy2", bus.busy, 0);

      run_op("multu_small", 2'b00, 32'h00000003, 32'h00000005, 32, 32'h00000000, 32'h0000000F);

      // async reset mid-ITER
      bus.op = 2'b00; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      chk("pre_rst_busy", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_done", bus.done, 0);
      chk("mid_rst_hi", bus.hi, 0);
      chk("mid_rst_lo", bus.lo, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_busy", bus.busy, 0);

      run_op("divu_100d7", 2'b10, 32'd100, 32'd7, 32, 32'd2, 32'd14);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Multiply/divide sequencer for the MIPS pipeline's EX stage. Executes MULTU, MULT, DIVU and DIV as fixed-latency iterative operations that issue every add, subtract and negate through one instance of the team's shared 32-bit ALU. Results land in architectural HI/LO registers that the pipeline reads with MFHI/MFLO. The pipeline stalls on `busy`.

## Interface
- `WIDTH`, 32: operand and HI/LO width; only 32 is supported.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `op` in 2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a` in 32: multiplicand or dividend (rs), captured on accept.
- `b` in 32: multiplier or divisor (rt), captured on accept.
- `abort` in 1: pipeline flush; kills the in-flight operation.
- `busy` out 1: high from the cycle after accept until DONE is left.
- `done` out 1: one-cycle pulse when HI/LO are updated.
- `hi` out 32: product[63:32] or remainder.
- `lo` out 32: product[31:0] or quotient.

## Operation
- States:
  - IDLE: `start`=1 latches a, b, op. Unsigned ops go to ITER; signed ops go to NEG_A.
  - NEG_A, NEG_B: replace the operand with 0 − x (ALU SUB) if its sign bit is set, else pass it. Record sign_a and sign_b.
  - ITER: 32 cycles, counter 0..31. Goes to NEG_LO (signed) or DONE (unsigned).
  - NEG_LO, NEG_HI: signed fix-up, then DONE.
  - DONE: HI/LO written, `done`=1, return to IDLE.
- Multiply step, with {acc, mq} = {0, |b|}:
  - If mq[0]: sum = acc + mcand via ALU ADD. Carry = (sum < acc), computed outside the ALU.
  - Then {carry, sum_or_acc, mq} shifts right by 1.
- Divide step (restoring), with {rem, q} = {0, |a|}:
  - Shift {rem, q} left by 1; msb = the bit shifted out of rem.
  - If msb or rem ≥ d: rem = rem − d via ALU SUB, q[0] = 1.
- Signed fix-up:
  - MULT, if sign_a^sign_b: lo = 0 − lo (SUB), then hi = ~hi + (lo==0) (ADD).
  - DIV: lo negated if sign_a^sign_b; hi negated if sign_a.
  - A fix-up cycle with nothing to negate passes its value through.
- Divide-by-zero follows the algorithm with no special case. DIVU x/0 gives lo=FFFFFFFF, hi=x. Signed fix-up then applies as normal.
- DIV 80000000/FFFFFFFF gives lo=80000000, hi=0. No trap.
- ALU opcodes used: ADD 0010, SUB 0110. Other ALU encodings are never driven. The `zero` output is unused.

## Timing
- Reset (async on `rst_n` low): state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0. Reset mid-operation discards the work.
- Latency is measured from the accept edge E0 to the edge after which `done` is high:
  - Unsigned: 32 cycles. Iterations run on E1..E32.
  - Signed: 36 cycles. NEG_A on E1, NEG_B on E2, ITER on E3..E34, NEG_LO on E35, NEG_HI on E36.
- `busy` rises after E0 and falls when DONE is left. Back-to-back `start` is accepted on the first IDLE cycle after DONE.
- `start` while not IDLE is ignored. Requests are not queued.
- `abort`:
  - Takes priority over every transition except reset.
  - Next edge: IDLE, `busy`=0, no `done`.
  - HI/LO keep their previous values.
  - `abort` and `start` together in IDLE: no accept.
- HI/LO change only on the DONE cycle edge and hold otherwise.

## Structure
- Shared package `mdu_pkg`:
  - op encodings
  - ALU control constants: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100
  - state enum: IDLE, NEG_A, NEG_B, ITER, NEG_LO, NEG_HI, DONE
- One sub-module: the shared 32-bit ALU, instantiated once. The FSM muxes its A, B and alu_control inputs per state.
- Carry and compare logic plus the shift registers are local to `mdu_seq`.

## Test plan
- MULTU FFFFFFFF×FFFFFFFF → hi=FFFFFFFE, lo=00000001. `done` exactly 32 cycles after accept; `busy` high throughout.
- MULT FFFFFFFD(−3)×00000005 → hi=FFFFFFFF, lo=FFFFFFF1. `done` at 36 cycles.
- DIV FFFFFFF9(−7)÷00000002 → lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU 00000007÷0 → lo=FFFFFFFF, hi=00000007.
- DIV 80000000÷FFFFFFFF → lo=80000000, hi=00000000.
- Control-path sequence:
  - Second `start` at iteration 5 is ignored.
  - `abort` at iteration 10 → IDLE next cycle, no `done`, HI/LO unchanged.
  - `rst_n` pulsed low mid-ITER → all outputs 0 immediately.
